// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values,
// message-schedule sigma functions and the scheduler state encoding.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, INIT, ROUNDS, FINAL} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial digest; the compressor loads these for a first block.
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_scheduler_if.sv
// Block-input handshake between the padding/block buffer and the scheduler.
interface sha256_msg_scheduler_if;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         block_first;

  modport master (output block_valid, block_data, block_first, input block_ready);
  modport slave  (input block_valid, block_data, block_first, output block_ready);
endinterface

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: round index to K[t], purely combinational.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);
  assign k = K[idx];
endmodule

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 sequencer: accepts a 512-bit block, streams W[0..63] with K[t],
// and emits the one-hot strobes that drive the compression datapath.
module sha256_msg_scheduler
  import sha256_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  sha256_msg_scheduler_if.slave   blk,
  output logic                    init_digest,
  output logic                    init_round,
  output logic                    partial_rounds,
  output logic                    update_digest,
  output logic                    first_block,
  output logic [31:0]             w_data,
  output logic [31:0]             k_out,
  output logic [5:0]              round_idx,
  output logic                    block_done
);

  state_t      state_reg, state_next;
  logic [5:0]  t_reg;
  logic        first_reg;
  logic [31:0] w_reg [16];
  logic [31:0] load_word [16];
  logic [31:0] w_new;
  logic [31:0] k_word;
  logic        accept;

  // Word 0 of the block sits in the top 32 bits.
  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign load_word[gi] = blk.block_data[511 - 32*gi -: 32];
  end

  // block_ready is high exactly in IDLE, so acceptance needs only valid.
  assign accept = (state_reg == IDLE) && blk.block_valid;
  assign w_new  = sigma1(w_reg[14]) + w_reg[9] + sigma0(w_reg[1]) + w_reg[0];

  sha256_k_rom u_k_rom (
    .idx (t_reg),
    .k   (k_word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Round counter: counts through ROUNDS and is held at 0 elsewhere, so
  // it leaves 63 only by rolling over on the way into FINAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                t_reg <= '0;
    else if (state_reg == ROUNDS) t_reg <= t_reg + 6'd1;
    else                         t_reg <= '0;
  end

  // Latch the first-of-message flag with the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    first_reg <= 1'b0;
    else if (accept) first_reg <= blk.block_first;
  end

  // 16-word schedule window: load on accept, shift one word per round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) w_reg[i] <= load_word[i];
    end else if (state_reg == ROUNDS) begin
      for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
      w_reg[15] <= w_new;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next      = state_reg;
    blk.block_ready = 1'b0;
    init_digest     = 1'b0;
    init_round      = 1'b0;
    partial_rounds  = 1'b0;
    update_digest   = 1'b0;
    block_done      = 1'b0;
    first_block     = 1'b0;
    w_data          = '0;
    k_out           = '0;
    round_idx       = '0;
    case (state_reg)
      IDLE: begin
        blk.block_ready = 1'b1;
        if (blk.block_valid) state_next = INIT;
      end
      INIT: begin
        init_digest = 1'b1;
        init_round  = 1'b1;
        first_block = first_reg;
        state_next  = ROUNDS;
      end
      ROUNDS: begin
        partial_rounds = 1'b1;
        w_data         = w_reg[0];
        k_out          = k_word;
        round_idx      = t_reg;
        if (t_reg == 6'd63) state_next = FINAL;
      end
      FINAL: begin
        update_digest = 1'b1;
        block_done    = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Scoreboard bench for sha256_msg_scheduler: the driver pushes the full
// expected strobe/word sequence of each accepted block; the monitor pops
// and compares on every strobe cycle and checks idle outputs otherwise.
module tb_sha256_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_digest, init_round, partial_rounds, update_digest;
  logic        first_block, block_done;
  logic [31:0] w_data, k_out;
  logic [5:0]  round_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sha256_msg_scheduler_if bif ();

  sha256_msg_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .blk            (bif),
    .init_digest    (init_digest),
    .init_round     (init_round),
    .partial_rounds (partial_rounds),
    .update_digest  (update_digest),
    .first_block    (first_block),
    .w_data         (w_data),
    .k_out          (k_out),
    .round_idx      (round_idx),
    .block_done     (block_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [31:0] kref [64];
  logic [31:0] mw [64];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // K[t] = first 32 fractional bits of cbrt(prime t), refined exactly.
  function automatic logic [31:0] kconst(input int p);
    real          r;
    longint       xi;
    logic [127:0] x, tgt;
    r   = $pow(real'(p), 1.0 / 3.0);
    xi  = longint'(r * 4294967296.0);
    x   = 128'(xi);
    tgt = 128'(p) << 96;
    for (int i = 0; i < 8 && (x * x * x > tgt); i++) x = x - 1;
    for (int i = 0; i < 8 && ((x + 1) * (x + 1) * (x + 1) <= tgt); i++) x = x + 1;
    return x[31:0];
  endfunction

  task automatic build_k();
    int n, c;
    bit is_p;
    n = 0;
    c = 2;
    while (n < 64) begin
      is_p = 1;
      for (int d = 2; d * d <= c; d++) if (c % d == 0) is_p = 0;
      if (is_p) begin
        kref[n] = kconst(c);
        n++;
      end
      c++;
    end
  endtask

  typedef struct {
    int          kind;   // 0 init, 1 round, 2 final
    int          at;
    logic        first;
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  t;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_block(input logic [511:0] d, input logic f, input int n);
    exp_t e;
    for (int i = 0; i < 16; i++) mw[i] = d[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) mw[i] = ms1(mw[i-2]) + mw[i-7] + ms0(mw[i-15]) + mw[i-16];
    e = '{kind: 0, at: n + 1, first: f, w: 32'h0, k: 32'h0, t: 6'd0};
    exp_q.push_back(e);
    for (int i = 0; i < 64; i++) begin
      e = '{kind: 1, at: n + 2 + i, first: 1'b0, w: mw[i], k: kref[i], t: 6'(i)};
      exp_q.push_back(e);
    end
    e = '{kind: 2, at: n + 66, first: 1'b0, w: 32'h0, k: 32'h0, t: 6'd0};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] obs_w [32][64];
  logic [31:0] obs_k [32][64];
  logic        obs_first [32];
  int          blk_cnt = -1;
  exp_t        me;
  int          mkind;
  bit          mok;

  always @(negedge clk) begin
    checks++;
    assert ($onehot0({init_round, partial_rounds, update_digest}) &&
            init_digest == init_round && block_done == update_digest)
    else begin
      errors++;
      $display("FAIL strobes at cycle %0d: ir=%b pr=%b ud=%b id=%b bd=%b",
               cyc, init_round, partial_rounds, update_digest, init_digest, block_done);
    end
    checks++;
    if (init_round || partial_rounds || update_digest) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d: ir=%b pr=%b ud=%b expected none",
                 cyc, init_round, partial_rounds, update_digest);
      end else begin
        me = exp_q.pop_front();
        mkind = init_round ? 0 : (partial_rounds ? 1 : 2);
        mok = (mkind == me.kind) && (cyc == me.at) && !bif.block_ready;
        if (me.kind == 1)
          mok = mok && w_data == me.w && k_out == me.k && round_idx == me.t && !first_block;
        else
          mok = mok && w_data == 0 && k_out == 0 && round_idx == 0 && first_block == me.first;
        if (!mok)
          $display("FAIL sequence at cycle %0d: kind=%0d w=%h k=%h t=%0d first=%b rdy=%b expected kind=%0d cycle=%0d w=%h k=%h t=%0d first=%b rdy=0",
                   cyc, mkind, w_data, k_out, round_idx, first_block, bif.block_ready,
                   me.kind, me.at, me.w, me.k, me.t, me.first);
        if (!mok) errors++;
        if (mkind == 0) begin
          blk_cnt++;
          if (blk_cnt < 32) obs_first[blk_cnt] = first_block;
        end else if (mkind == 1 && blk_cnt >= 0 && blk_cnt < 32) begin
          obs_w[blk_cnt][round_idx] = w_data;
          obs_k[blk_cnt][round_idx] = k_out;
        end else if (mkind == 2) begin
          $display("block %0d done at cycle %0d", blk_cnt, cyc);
        end
      end
    end else begin
      mok = w_data == 0 && k_out == 0 && round_idx == 0 && !first_block && bif.block_ready;
      if (exp_q.size() != 0 && exp_q[0].at <= cyc) mok = 0;
      if (!mok) begin
        errors++;
        $display("FAIL idle at cycle %0d: w=%h k=%h t=%0d first=%b rdy=%b pending=%0d expected zeros, ready, nothing due",
                 cyc, w_data, k_out, round_idx, first_block, bif.block_ready, exp_q.size());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; holds the block until accepted, returns acceptance cycle.
  task automatic send(input logic [511:0] d, input logic f, output int acc);
    bit done;
    acc = -1;
    done = 0;
    bif.block_valid = 1'b1;
    bif.block_data  = d;
    bif.block_first = f;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bif.block_ready) begin
        acc = cyc;
        push_block(d, f, acc);
        @(posedge clk);
        @(negedge clk);
        bif.block_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      bif.block_valid = 1'b0;
      $display("FAIL accept_timeout: block never accepted within 200 cycles");
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic wait_cycle(input int target);
    for (int i = 0; i < 300 && cyc < target; i++) @(negedge clk);
  endtask

  logic [511:0] abc_blk;
  int na, nb, nc, n_prev, n_cur;
  bit hit;

  initial begin
    bif.block_valid = 1'b0;
    bif.block_data  = '0;
    bif.block_first = 1'b0;
    build_k();

    repeat (3) @(negedge clk);
    chk("reset_outputs", longint'({init_digest, init_round, partial_rounds, update_digest,
                                    first_block, block_done}), 0);
    chk("reset_words", longint'({w_data, k_out}), 0);
    chk("reset_ready", longint'(bif.block_ready), 1);
    reset_n = 1'b1;
    @(negedge clk);

    // "abc" block followed by a block held during the busy period.
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    send(abc_blk, 1'b1, na);
    send(rand_block(), 1'b0, nb);
    chk("back_to_back_accept", nb, na + 67);
    wait_cycle(nb + 68);
    chk("abc_first_block", longint'(obs_first[0]), 1);
    chk("abc_w0", obs_w[0][0], 32'h61626380);
    chk("abc_k0", obs_k[0][0], 32'h428a2f98);
    chk("abc_w15", obs_w[0][15], 32'h00000018);
    chk("abc_w16", obs_w[0][16], 32'h61626380);
    chk("abc_w17", obs_w[0][17], 32'h000f0000);
    chk("abc_k63", obs_k[0][63], 32'hc67178f2);
    chk("second_first_block", longint'(obs_first[1]), 0);

    // Reset in the middle of the rounds.
    send(rand_block(), 1'b1, nc);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (partial_rounds && round_idx == 6'd30) hit = 1;
      else @(negedge clk);
    end
    chk("reached_t30", longint'(hit), 1);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_outputs", longint'({init_digest, init_round, partial_rounds, update_digest,
                                       first_block, block_done, w_data, k_out, round_idx}), 0);
    chk("midreset_ready", longint'(bif.block_ready), 1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("postreset_ready", longint'(bif.block_ready), 1);
    chk("postreset_strobes", longint'({partial_rounds, update_digest, block_done}), 0);
    repeat (80) @(negedge clk);

    // Random back-to-back blocks.
    n_prev = -1;
    for (int b = 0; b < 16; b++) begin
      send(rand_block(), 1'($urandom_range(1, 0)), n_cur);
      if (n_prev >= 0) chk("random_spacing", n_cur - n_prev, 67);
      n_prev = n_cur;
    end
    wait_cycle(n_prev + 70);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
